apb_timer_mc: RTL and testbench

Parametrised multi-channel APB timer, successor of the single-channel 64-bit timer. It holds N_CH independent counters of CNT_W bits behind one APB slave. Each channel has a clock divider, a compare register, a debug halt and three counting modes: free-run, periodic auto-clear and one-shot. Per-channel interrupts are ORed onto one interrupt line, and the per-channel vector is also exported.

---
 rtl/apb_timer_pkg.sv | 42 ++++
 rtl/timer_channel.sv | 130 +++++++++++++
 rtl/apb_timer_mc.sv | 67 ++++++
 tb/tb_apb_timer_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, TCR fields and counting modes shared by apb_timer_mc
package apb_timer_pkg;

  localparam logic [4:0] OFF_TCR   = 5'h00;
  localparam logic [4:0] OFF_TDR0  = 5'h04;
  localparam logic [4:0] OFF_TDR1  = 5'h08;
  localparam logic [4:0] OFF_TCMP0 = 5'h0C;
  localparam logic [4:0] OFF_TCMP1 = 5'h10;
  localparam logic [4:0] OFF_TIER  = 5'h14;
  localparam logic [4:0] OFF_TISR  = 5'h18;
  localparam logic [4:0] OFF_THCSR = 5'h1C;

  localparam int TCR_EN       = 0;
  localparam int TCR_DIV_EN   = 1;
  localparam int TCR_DIV_LSB  = 8;
  localparam int TCR_DIV_MSB  = 11;
  localparam int TCR_MODE_LSB = 12;
  localparam int TCR_MODE_MSB = 13;

  localparam logic [31:0] TCR_RESET = 32'h0000_0100;
  localparam logic [3:0]  DIV_MAX   = 4'd8;
  localparam int unsigned CH_STRIDE = 32'h20;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: registers, divider, counter, compare and interrupt
module timer_channel
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sel,
  input  logic        pwrite,
  input  logic [4:0]  offset,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic        dbg_mode,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        irq
);

  logic             timer_en, div_en, int_en, int_st, halt_req, halt_ack;
  logic [3:0]       div_val;
  mode_e            mode;
  logic [CNT_W-1:0] counter, cmp, counter_nxt;
  logic [7:0]       int_cnt, int_cnt_nxt, div_top;
  logic             wr, tick, match, advance, en_nxt;
  logic [31:0]      tcr_cur, tcr_new;
  logic             tcr_wr, tcr_illegal, tcr_ok;
  logic [63:0]      cnt_ext, cmp_ext, cnt_wr, cmp_wr;
  logic             unused_hi;

  assign wr       = sel & pwrite;
  assign halt_ack = halt_req & dbg_mode;
  assign cnt_ext  = 64'(counter);
  assign cmp_ext  = 64'(cmp);

  assign tcr_cur = {18'b0, mode, div_val, 6'b0, div_en, timer_en};
  assign tcr_new = apply_strb(tcr_cur, pwdata, pstrb);

  // Divider settings may not change under a running timer; the whole write is rejected.
  assign tcr_illegal = (tcr_new[TCR_DIV_MSB:TCR_DIV_LSB] > DIV_MAX)
                    || (tcr_new[TCR_MODE_MSB:TCR_MODE_LSB] == MODE_RSVD)
                    || (timer_en && tcr_new[TCR_EN]
                        && ((tcr_new[TCR_DIV_EN] != div_en)
                            || (tcr_new[TCR_DIV_MSB:TCR_DIV_LSB] != div_val)));
  assign tcr_wr = wr && (offset == OFF_TCR);
  assign tcr_ok = tcr_wr && !tcr_illegal;
  assign slverr = tcr_wr && tcr_illegal;

  assign div_top = 8'((9'd1 << div_val) - 9'd1);
  assign tick    = !div_en || (int_cnt == div_top);
  assign match   = (counter == cmp);
  assign advance = timer_en && !halt_ack && tick;
  assign irq     = int_st & int_en;

  // Upper halves fall away on truncation when CNT_W is 32.
  assign unused_hi = ^{cnt_wr[63:32], cmp_wr[63:32]};

  always_comb begin
    cnt_wr = cnt_ext;
    cmp_wr = cmp_ext;
    if (offset == OFF_TDR0)  cnt_wr[31:0]  = apply_strb(cnt_ext[31:0],  pwdata, pstrb);
    if (offset == OFF_TDR1)  cnt_wr[63:32] = apply_strb(cnt_ext[63:32], pwdata, pstrb);
    if (offset == OFF_TCMP0) cmp_wr[31:0]  = apply_strb(cmp_ext[31:0],  pwdata, pstrb);
    if (offset == OFF_TCMP1) cmp_wr[63:32] = apply_strb(cmp_ext[63:32], pwdata, pstrb);
  end

  always_comb begin
    counter_nxt = counter;
    en_nxt      = timer_en;
    int_cnt_nxt = int_cnt + 8'd1;
    if (!timer_en || !div_en || tick) int_cnt_nxt = 8'd0;

    if (tcr_ok) en_nxt = tcr_new[TCR_EN];
    else if (advance && match && (mode == MODE_ONESHOT)) en_nxt = 1'b0;

    if (wr && ((offset == OFF_TDR0) || (offset == OFF_TDR1))) begin
      counter_nxt = cnt_wr[CNT_W-1:0];
    end else if (tcr_ok && timer_en && !tcr_new[TCR_EN]) begin
      counter_nxt = '0;
    end else if (advance) begin
      if (match && (mode == MODE_PERIODIC))     counter_nxt = '0;
      else if (!(match && (mode == MODE_ONESHOT))) counter_nxt = counter + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      timer_en <= TCR_RESET[TCR_EN];
      div_en   <= TCR_RESET[TCR_DIV_EN];
      div_val  <= TCR_RESET[TCR_DIV_MSB:TCR_DIV_LSB];
      mode     <= mode_e'(TCR_RESET[TCR_MODE_MSB:TCR_MODE_LSB]);
      counter  <= '0;
      cmp      <= '1;
      int_cnt  <= 8'd0;
      int_en   <= 1'b0;
      int_st   <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      timer_en <= en_nxt;
      counter  <= counter_nxt;
      int_cnt  <= int_cnt_nxt;
      if (tcr_ok) begin
        div_en  <= tcr_new[TCR_DIV_EN];
        div_val <= tcr_new[TCR_DIV_MSB:TCR_DIV_LSB];
        mode    <= mode_e'(tcr_new[TCR_MODE_MSB:TCR_MODE_LSB]);
      end
      if (wr && ((offset == OFF_TCMP0) || (offset == OFF_TCMP1))) cmp <= cmp_wr[CNT_W-1:0];
      if (wr && (offset == OFF_TIER) && pstrb[0]) int_en <= pwdata[0];
      if (match) int_st <= 1'b1;
      else if (wr && (offset == OFF_TISR) && pstrb[0] && pwdata[0]) int_st <= 1'b0;
      if (wr && (offset == OFF_THCSR) && pstrb[0]) halt_req <= pwdata[0];
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFF_TCR:   rdata = tcr_cur;
      OFF_TDR0:  rdata = cnt_ext[31:0];
      OFF_TDR1:  rdata = cnt_ext[63:32];
      OFF_TCMP0: rdata = cmp_ext[31:0];
      OFF_TCMP1: rdata = cmp_ext[63:32];
      OFF_TIER:  rdata = {31'b0, int_en};
      OFF_TISR:  rdata = {31'b0, int_st};
      OFF_THCSR: rdata = {30'b0, halt_ack, halt_req};
      default:   rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/apb_timer_mc.sv
// rtl/apb_timer_mc.sv - multi-channel APB timer top: address decode, read mux, error and interrupt OR
module apb_timer_mc
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int N_CH  = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            tim_psel,
  input  logic            tim_penable,
  input  logic            tim_pwrite,
  input  logic [11:0]     tim_paddr,
  input  logic [31:0]     tim_pwdata,
  input  logic [3:0]      tim_pstrb,
  input  logic            dbg_mode,
  output logic [31:0]     tim_prdata,
  output logic            tim_pready,
  output logic            tim_pslverr,
  output logic            tim_int,
  output logic [N_CH-1:0] tim_int_ch
);

  localparam logic [11:0] MAP_END = 12'(N_CH * CH_STRIDE);

  logic            mapped, access;
  logic [1:0]      ch_idx;
  logic [4:0]      reg_off;
  logic [N_CH-1:0] sel_ch, slverr_ch;
  logic [31:0]     rdata_ch [N_CH];

  assign tim_pready = tim_psel & tim_penable;
  assign mapped     = (tim_paddr < MAP_END) && (tim_paddr[1:0] == 2'b00);
  assign access     = tim_pready && mapped;
  assign ch_idx     = tim_paddr[6:5];
  assign reg_off    = tim_paddr[4:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign sel_ch[i] = access && (ch_idx == 2'(i));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .sel      (sel_ch[i]),
      .pwrite   (tim_pwrite),
      .offset   (reg_off),
      .pwdata   (tim_pwdata),
      .pstrb    (tim_pstrb),
      .dbg_mode (dbg_mode),
      .rdata    (rdata_ch[i]),
      .slverr   (slverr_ch[i]),
      .irq      (tim_int_ch[i])
    );
  end

  // Unselected or unmapped accesses return zero.
  always_comb begin
    tim_prdata = 32'h0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch[i]) tim_prdata = rdata_ch[i];
    end
  end

  assign tim_pslverr = |slverr_ch;
  assign tim_int     = |tim_int_ch;

endmodule

// File: tb/tb_apb_timer_mc.sv
// tb/tb_apb_timer_mc.sv - self-checking bench for apb_timer_mc (64-bit/2-channel and 32-bit/1-channel)
module tb_apb_timer_mc;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        psel = 1'b0, psel32 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic        dbg_mode = 1'b0;

  logic [31:0] prdata, prdata32;
  logic        pready, pready32, pslverr, pslverr32, tim_int, tim_int32;
  logic [1:0]  tim_int_ch;
  logic [0:0]  tim_int_ch32;

  always #5 sys_clk = ~sys_clk;

  apb_timer_mc #(.CNT_W(64), .N_CH(2)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tim_psel(psel), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb), .dbg_mode(dbg_mode),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr),
    .tim_int(tim_int), .tim_int_ch(tim_int_ch)
  );

  apb_timer_mc #(.CNT_W(32), .N_CH(1)) u_dut32 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .tim_psel(psel32), .tim_penable(penable), .tim_pwrite(pwrite),
    .tim_paddr(paddr), .tim_pwdata(pwdata), .tim_pstrb(pstrb), .dbg_mode(dbg_mode),
    .tim_prdata(prdata32), .tim_pready(pready32), .tim_pslverr(pslverr32),
    .tim_int(tim_int32), .tim_int_ch(tim_int_ch32)
  );

  typedef struct {
    bit          d32;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add_vec(input bit d32, input bit wr, input logic [11:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic [31:0] exp_rd, input bit exp_err);
    vec_t v;
    v.d32 = d32; v.wr = wr; v.addr = addr; v.data = data;
    v.strb = strb; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Two-cycle APB transfer; response sampled mid access cycle.
  task automatic apb_op(input bit d32, input bit wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err);
    @(negedge sys_clk);
    psel = !d32; psel32 = d32; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = wr ? strb : 4'h0;
    @(negedge sys_clk);
    penable = 1'b1;
    #1;
    rd  = d32 ? prdata32 : prdata;
    err = d32 ? pslverr32 : pslverr;
    check("pready", {31'b0, d32 ? pready32 : pready}, 32'd1);
    @(posedge sys_clk);
    #1;
    psel = 1'b0; psel32 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    apb_op(1'b0, 1'b0, addr, 32'h0, 4'h0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic wr_op(input string name, input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        err;
    apb_op(1'b0, 1'b1, addr, data, 4'hF, rd, err);
    check(name, {31'b0, err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_prdata",  prdata, 32'h0);
    check("rst_pready",  {31'b0, pready}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_int",     {31'b0, tim_int}, 32'd0);
    check("rst_int_ch",  {30'b0, tim_int_ch}, 32'd0);

    // Reset values of channel 1, unmapped and misaligned accesses
    add_vec(0, 0, 12'h020, 0, 0, 32'h0000_0100, 0);
    add_vec(0, 0, 12'h024, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h028, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h02C, 0, 0, 32'hFFFF_FFFF, 0);
    add_vec(0, 0, 12'h030, 0, 0, 32'hFFFF_FFFF, 0);
    add_vec(0, 0, 12'h034, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h038, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h03C, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h040, 0, 0, 32'h0, 0);
    add_vec(0, 1, 12'h040, 32'h1, 4'hF, 0, 0);
    add_vec(0, 0, 12'h022, 0, 0, 32'h0, 0);
    add_vec(0, 1, 12'h02E, 32'h0, 4'hF, 0, 0);
    add_vec(0, 0, 12'h02C, 0, 0, 32'hFFFF_FFFF, 0);
    // Byte strobes
    add_vec(0, 1, 12'h02C, 32'hA5A5_A5A5, 4'b0101, 0, 0);
    add_vec(0, 0, 12'h02C, 0, 0, 32'hFFA5_FFA5, 0);
    // Illegal TCR writes
    add_vec(0, 1, 12'h020, 32'h0000_0900, 4'hF, 0, 1);
    add_vec(0, 0, 12'h020, 0, 0, 32'h0000_0100, 0);
    add_vec(0, 1, 12'h020, 32'h0000_3000, 4'hF, 0, 1);
    add_vec(0, 0, 12'h020, 0, 0, 32'h0000_0100, 0);
    // Channel 0 free-run wrap of the 64-bit counter (reads step 2 cycles apart)
    add_vec(0, 1, 12'h008, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add_vec(0, 1, 12'h004, 32'hFFFF_FFFE, 4'hF, 0, 0);
    add_vec(0, 1, 12'h000, 32'h0000_0001, 4'hF, 0, 0);
    add_vec(0, 0, 12'h004, 0, 0, 32'hFFFF_FFFF, 0);
    add_vec(0, 0, 12'h008, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h004, 0, 0, 32'h3, 0);
    add_vec(0, 1, 12'h000, 32'h0000_0003, 4'hF, 0, 1);
    add_vec(0, 0, 12'h000, 0, 0, 32'h0000_0001, 0);
    add_vec(0, 1, 12'h000, 32'h0, 4'hF, 0, 0);
    add_vec(0, 0, 12'h004, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h018, 0, 0, 32'h1, 0);
    add_vec(0, 1, 12'h018, 32'h1, 4'hF, 0, 0);
    add_vec(0, 0, 12'h018, 0, 0, 32'h0, 0);
    // 32-bit instance: TDR1 inert, wrap at 2^32, single channel map
    add_vec(1, 1, 12'h008, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add_vec(1, 0, 12'h008, 0, 0, 32'h0, 0);
    add_vec(1, 1, 12'h004, 32'hFFFF_FFFE, 4'hF, 0, 0);
    add_vec(1, 1, 12'h000, 32'h0000_0001, 4'hF, 0, 0);
    add_vec(1, 0, 12'h004, 0, 0, 32'hFFFF_FFFF, 0);
    add_vec(1, 0, 12'h008, 0, 0, 32'h0, 0);
    add_vec(1, 0, 12'h004, 0, 0, 32'h3, 0);
    add_vec(1, 1, 12'h000, 32'h0, 4'hF, 0, 0);
    add_vec(1, 0, 12'h020, 0, 0, 32'h0, 0);
    // Channel 1 untouched by channel 0 activity
    add_vec(0, 0, 12'h020, 0, 0, 32'h0000_0100, 0);
    add_vec(0, 0, 12'h024, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h038, 0, 0, 32'h0, 0);
    add_vec(0, 0, 12'h02C, 0, 0, 32'hFFA5_FFA5, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apb_op(vecs[i].d32, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err);
      if (!vecs[i].wr) check($sformatf("vec[%0d] rdata @%03h", i, vecs[i].addr), rd, vecs[i].exp_rd);
      check($sformatf("vec[%0d] pslverr @%03h", i, vecs[i].addr), {31'b0, err}, {31'b0, vecs[i].exp_err});
    end

    // Periodic: cmp=10, div 2^2 -> each value held 4 cycles, period 44
    wr_op("per_cmp0", 12'h00C, 32'd10);
    wr_op("per_cmp1", 12'h010, 32'd0);
    wr_op("per_tcr",  12'h000, 32'h0000_1203);
    for (int n = 1; n <= 30; n++) begin
      rd_chk($sformatf("periodic_cnt[%0d]", n), 12'h004, 32'(((2 * n - 1) / 4) % 11));
    end
    rd_chk("per_isr", 12'h018, 32'h1);
    check("per_int_masked", {31'b0, tim_int}, 32'd0);
    wr_op("per_ier", 12'h014, 32'h1);
    check("per_int_on",    {31'b0, tim_int}, 32'd1);
    check("per_int_ch_on", {30'b0, tim_int_ch}, 32'b01);
    wr_op("per_stop", 12'h000, 32'h0000_1202);
    wr_op("per_w1c",  12'h018, 32'h1);
    check("per_int_off", {31'b0, tim_int}, 32'd0);
    rd_chk("per_isr_clr", 12'h018, 32'h0);

    // One-shot: stops at cmp=5 and clears timer_en
    wr_op("os_cmp0", 12'h00C, 32'd5);
    wr_op("os_tcr",  12'h000, 32'h0000_2001);
    rd_chk("os_cnt1", 12'h004, 32'd1);
    rd_chk("os_cnt2", 12'h004, 32'd3);
    rd_chk("os_cnt3", 12'h004, 32'd5);
    rd_chk("os_cnt4", 12'h004, 32'd5);
    rd_chk("os_tcr_rd", 12'h000, 32'h0000_2000);
    check("os_int", {31'b0, tim_int}, 32'd1);

    // Halt: effective only with dbg_mode=1
    dbg_mode = 1'b1;
    wr_op("halt_tcr", 12'h000, 32'h0000_0001);
    rd_chk("halt_cnt_run", 12'h004, 32'd6);
    wr_op("halt_req", 12'h01C, 32'h1);
    rd_chk("halt_cnt_frozen", 12'h004, 32'd9);
    rd_chk("halt_thcsr_ack", 12'h01C, 32'h3);
    dbg_mode = 1'b0;
    rd_chk("halt_cnt_resume", 12'h004, 32'd10);
    rd_chk("halt_thcsr_noack", 12'h01C, 32'h1);
    rd_chk("halt_cnt_run2", 12'h004, 32'd14);
    wr_op("halt_clr", 12'h01C, 32'h0);
    wr_op("halt_stop", 12'h000, 32'h0);
    rd_chk("ch1_isr_final", 12'h038, 32'h0);
    check("ch1_int_final", {31'b0, tim_int_ch[1]}, 32'd0);
    check("pre_rst_int", {31'b0, tim_int}, 32'd1);

    // Reset during the access cycle of a write: nothing commits
    @(negedge sys_clk);
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h034; pwdata = 32'h1; pstrb = 4'hF; penable = 1'b0;
    @(negedge sys_clk);
    penable = 1'b1; sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_prdata",  prdata, 32'h0);
    check("mid_rst_pready",  {31'b0, pready}, 32'd0);
    check("mid_rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("mid_rst_int",     {31'b0, tim_int}, 32'd0);
    check("mid_rst_int_ch",  {30'b0, tim_int_ch}, 32'd0);
    rd_chk("mid_rst_ch1_ier", 12'h034, 32'h0);
    rd_chk("mid_rst_ch0_cnt", 12'h004, 32'h0);
    rd_chk("mid_rst_ch0_tcr", 12'h000, 32'h0000_0100);
    rd_chk("mid_rst_ch0_cmp", 12'h00C, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
